cfs_apb_master_arbiter: RTL

- Shares one APB master port (cfs_apb_if signal set) between NUM_REQ internal requesters using round-robin arbitration.
- Sequences the APB SETUP/ACCESS phases for each transfer and returns read data and error status to the winning requester.
- Aborts stalled transfers with a programmable pready timeout.
- Sits between agent-side sequencers/models and the DUT APB slave port.

---
 rtl/cfs_apb_arb_pkg.sv | 42 ++++
 rtl/cfs_apb_rr_arbiter.sv | 42 ++++
 rtl/cfs_apb_master_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cfs_apb_arb_pkg.sv
// rtl/cfs_apb_arb_pkg.sv - shared types, widths and helpers for the APB master arbiter
//
// Contents:
//   arb_state_t            IDLE / SETUP / ACCESS transfer sequencer states
//   CFS_APB_ARB_ADDR_W     default APB address width (CFS_APB_MAX_ADDR_WIDTH)
//   CFS_APB_ARB_DATA_W     default APB data width (CFS_APB_MAX_DATA_WIDTH)
//   cnt_width()            timeout counter width, clog2(TIMEOUT_CYCLES+1), minimum 1
//   idx_width()            requester index width, clog2(NUM_REQ), minimum 1

`ifndef CFS_APB_MAX_ADDR_WIDTH
`define CFS_APB_MAX_ADDR_WIDTH 16
`endif

`ifndef CFS_APB_MAX_DATA_WIDTH
`define CFS_APB_MAX_DATA_WIDTH 32
`endif

package cfs_apb_arb_pkg;

    localparam int CFS_APB_ARB_ADDR_W = `CFS_APB_MAX_ADDR_WIDTH;
    localparam int CFS_APB_ARB_DATA_W = `CFS_APB_MAX_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    // A disabled timeout (0) still gets a 1-bit counter so no zero-width vector exists.
    function automatic int cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int num_req);
        int w;
        w = $clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cfs_apb_rr_arbiter.sv
// rtl/cfs_apb_rr_arbiter.sv - combinational pointer-based round-robin pick
//
// Ports:
//   valid      in   NUM_REQ  request vector
//   ptr        in   IDX_W    last granted requester; search starts at ptr+1
//   grant      out  NUM_REQ  one-hot grant (all zero when nothing is valid)
//   grant_idx  out  IDX_W    index of the granted requester
//   grant_any  out  1        at least one request is valid

module cfs_apb_rr_arbiter
    import cfs_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int idx;

    // Offsets 1..NUM_REQ visit every requester once, the last one being ptr itself,
    // so the most recent winner has the lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && valid[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfs_apb_master_arbiter.sv
// rtl/cfs_apb_master_arbiter.sv - round-robin sharing of one APB master port with pready timeout
//
// Ports:
//   pclk, preset_n                clock, synchronous active-low reset
//   req_valid/write/addr/wdata    per-requester request, addr/wdata flattened (i*W +: W)
//   req_ready                     one-hot accept, combinational, only while IDLE
//   rsp_valid                     one-hot completion pulse, one cycle after the transfer ends
//   rsp_rdata/slverr/timeout      response payload qualified by rsp_valid
//   psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr   APB master port

module cfs_apb_master_arbiter
    import cfs_apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = CFS_APB_ARB_ADDR_W,
    parameter int DATA_W         = CFS_APB_ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pslverr
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   id;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               timeout_hit;

    cfs_apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Only one transfer in flight: requests are accepted solely while IDLE.
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    // The current ACCESS cycle is the TIMEOUT_CYCLES-th one seen with pready low.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(cnt) + 1) == TIMEOUT_CYCLES);

    // paddr/pwrite/pwdata double as the latched request payload; they hold their
    // last value outside transfers.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            id          <= '0;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        id      <= grant_idx;
                        ptr     <= grant_idx;
                        pwrite  <= req_write[grant_idx];
                        paddr   <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        pwdata  <= req_write[grant_idx] ?
                                   req_wdata[int'(grant_idx)*DATA_W +: DATA_W] : '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (pready) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid[id] <= 1'b1;
                        rsp_rdata     <= pwrite ? '0 : prdata;
                        rsp_slverr    <= pslverr;
                        rsp_timeout   <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (timeout_hit) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_valid[id] <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_slverr    <= 1'b1;
                        rsp_timeout   <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
